// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between two requesters.
// Latency: uncontended req at edge N -> ack in cycle N+2, rdata valid N+3.
// Backpressure: requesters hold req until ack; halt blocks new grants only.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  halt,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p0_ack,
    output logic                  p1_ack,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy,
    output logic                  grant
);

    typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

    state_t state, state_nxt;
    logic   last_winner;
    logic   win_nxt;
    logic   start;
    logic   cur_we;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        win_nxt   = grant;
        case (state)
            IDLE: begin
                if (!halt && (p0_req || p1_req)) begin
                    start     = 1'b1;
                    state_nxt = GRANT;
                    win_nxt   = (p0_req && p1_req) ? ~last_winner : p1_req;
                end
            end
            GRANT: state_nxt = DONE;
            DONE: begin
                // The port just acked still has req high; only the other one may chain.
                if (!halt && (grant ? p0_req : p1_req)) begin
                    start     = 1'b1;
                    state_nxt = GRANT;
                    win_nxt   = ~grant;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= IDLE;
            last_winner <= 1'b1;
            grant       <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            ram_we      <= 1'b0;
            cur_we      <= 1'b0;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
        end else begin
            state <= state_nxt;
            if (state == DONE && !cur_we) begin
                if (grant) p1_rdata <= ram_rdata;
                else       p0_rdata <= ram_rdata;
            end
            if (start) begin
                grant       <= win_nxt;
                last_winner <= win_nxt;
                ram_addr    <= win_nxt ? p1_addr  : p0_addr;
                ram_wdata   <= win_nxt ? p1_wdata : p0_wdata;
                ram_we      <= win_nxt ? p1_we    : p0_we;
                cur_we      <= win_nxt ? p1_we    : p0_we;
            end else begin
                ram_we <= 1'b0;
            end
        end
    end

    assign p0_ack = (state == DONE) && !grant;
    assign p1_ack = (state == DONE) &&  grant;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with a behavioural RAM and
// a transaction-level memory/arbitration reference model.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        resetn;
    logic        halt;
    logic [1:0]  req_d;
    logic [1:0]  we_d;
    logic [7:0]  addr_d  [2];
    logic [15:0] wdata_d [2];

    logic        p0_ack, p1_ack;
    logic [15:0] p0_rdata, p1_rdata;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;
    logic        busy, grant;

    logic [1:0]  ack_v;
    logic [15:0] rdata_v [2];

    logic [15:0] ram_mem   [0:255];
    logic [15:0] model_mem [0:255];
    logic [15:0] exp_rd    [2];

    int tests = 0;
    int fails = 0;
    int wait_cnt [2];
    int other;
    int exp_port;
    logic exp_regrant;
    logic exp_w;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .halt      (halt),
        .p0_req    (req_d[0]),
        .p0_we     (we_d[0]),
        .p0_addr   (addr_d[0]),
        .p0_wdata  (wdata_d[0]),
        .p1_req    (req_d[1]),
        .p1_we     (we_d[1]),
        .p1_addr   (addr_d[1]),
        .p1_wdata  (wdata_d[1]),
        .p0_ack    (p0_ack),
        .p1_ack    (p1_ack),
        .p0_rdata  (p0_rdata),
        .p1_rdata  (p1_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .busy      (busy),
        .grant     (grant)
    );

    assign ack_v      = {p1_ack, p0_ack};
    assign rdata_v[0] = p0_rdata;
    assign rdata_v[1] = p1_rdata;

    // Synchronous single-port RAM: read data appears the cycle after the address.
    always @(posedge clock) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One uncontended access starting from IDLE; returns one cycle after the ack.
    task automatic do_txn(input int p, input logic we, input logic [7:0] addr, input logic [15:0] wdata);
        req_d[p]   = 1'b1;
        we_d[p]    = we;
        addr_d[p]  = addr;
        wdata_d[p] = wdata;
        tick();
        check("txn_grant_busy", busy, 1);
        check("txn_grant_port", grant, p);
        check("txn_ram_addr", ram_addr, addr);
        check("txn_ram_we", ram_we, we);
        check("txn_no_ack_in_grant", ack_v, 0);
        if (we) check("txn_ram_wdata", ram_wdata, wdata);
        tick();
        check("txn_ack", ack_v, (p == 1) ? 2'b10 : 2'b01);
        check("txn_we_low_done", ram_we, 0);
        check("txn_rdata_before", rdata_v[p], exp_rd[p]);
        req_d[p] = 1'b0;
        if (we) model_mem[addr] = wdata;
        else    exp_rd[p] = model_mem[addr];
        tick();
        check("txn_ack_clear", ack_v, 0);
        check("txn_idle", busy, 0);
        check("txn_rdata_after", rdata_v[p], exp_rd[p]);
        check("txn_we_idle", ram_we, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i]   = 16'h0000;
            model_mem[i] = 16'h0000;
        end
        ram_rdata   = 16'h0000;
        exp_rd[0]   = 16'h0000;
        exp_rd[1]   = 16'h0000;
        wait_cnt[0] = 0;
        wait_cnt[1] = 0;
        exp_regrant = 1'b0;
        exp_port    = 0;

        // Reset with both ports requesting
        resetn = 1'b0; halt = 1'b0;
        req_d = 2'b11; we_d = 2'b00;
        addr_d[0] = 8'h05; addr_d[1] = 8'h06;
        wdata_d[0] = 16'h0; wdata_d[1] = 16'h0;
        tick();
        tick();
        check("rst_ack", ack_v, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_p0_rdata", p0_rdata, 0);
        check("rst_p1_rdata", p1_rdata, 0);
        resetn = 1'b1;
        tick();
        check("rst_first_busy", busy, 1);
        check("rst_first_grant", grant, 0);
        check("rst_first_addr", ram_addr, 8'h05);
        tick();
        check("rst_first_ack", ack_v, 2'b01);
        req_d[0] = 1'b0;
        tick();
        check("rst_chain_grant", grant, 1);
        check("rst_chain_addr", ram_addr, 8'h06);
        tick();
        check("rst_chain_ack", ack_v, 2'b10);
        req_d[1] = 1'b0;
        tick();
        check("rst_chain_idle", busy, 0);

        // Write then read on port 0
        do_txn(0, 1'b1, 8'h12, 16'hBEEF);
        do_txn(0, 1'b0, 8'h12, 16'h0000);
        check("wr_rd_beef", p0_rdata, 16'hBEEF);

        // Contention: alternating grants, starting with port 0 (port 1 won last)
        do_txn(0, 1'b1, 8'h01, 16'h1111);
        do_txn(1, 1'b1, 8'h02, 16'h2222);
        req_d = 2'b11; we_d = 2'b00;
        addr_d[0] = 8'h01; addr_d[1] = 8'h02;
        exp_w = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("cont_busy", busy, 1);
            check("cont_grant", grant, exp_w);
            check("cont_p0_rdata", p0_rdata, exp_rd[0]);
            check("cont_p1_rdata", p1_rdata, exp_rd[1]);
            tick();
            check("cont_ack", ack_v, exp_w ? 2'b10 : 2'b01);
            exp_rd[exp_w] = model_mem[addr_d[exp_w]];
            if (k == 3) req_d = 2'b00;
            exp_w = ~exp_w;
        end
        tick();
        check("cont_idle", busy, 0);
        check("cont_p0_val", p0_rdata, 16'h1111);
        check("cont_p1_val", p1_rdata, 16'h2222);

        // Halt raised while port 1 is in GRANT with port 0 pending
        req_d[1] = 1'b1; we_d[1] = 1'b0; addr_d[1] = 8'h02;
        tick();
        check("halt_p1_grant", grant, 1);
        check("halt_p1_busy", busy, 1);
        req_d[0] = 1'b1; we_d[0] = 1'b0; addr_d[0] = 8'h01;
        halt = 1'b1;
        tick();
        check("halt_p1_ack", ack_v, 2'b10);
        req_d[1] = 1'b0;
        exp_rd[1] = model_mem[8'h02];
        tick();
        check("halt_hold_busy1", busy, 0);
        check("halt_hold_ack1", ack_v, 0);
        tick();
        check("halt_hold_busy2", busy, 0);
        halt = 1'b0;
        tick();
        check("halt_release_busy", busy, 1);
        check("halt_release_grant", grant, 0);
        check("halt_release_addr", ram_addr, 8'h01);
        tick();
        check("halt_p0_ack", ack_v, 2'b01);
        req_d[0] = 1'b0;
        exp_rd[0] = model_mem[8'h01];
        tick();
        check("halt_end_idle", busy, 0);

        // Reset during a port 0 read
        req_d[0] = 1'b1; we_d[0] = 1'b0; addr_d[0] = 8'h01;
        tick();
        check("rmid_grant", busy, 1);
        resetn = 1'b0;
        tick();
        check("rmid_ack", ack_v, 0);
        check("rmid_busy", busy, 0);
        check("rmid_ram_addr", ram_addr, 0);
        check("rmid_ram_wdata", ram_wdata, 0);
        check("rmid_ram_we", ram_we, 0);
        check("rmid_grant_out", grant, 0);
        check("rmid_p0_rdata", p0_rdata, 0);
        check("rmid_p1_rdata", p1_rdata, 0);
        resetn = 1'b1;
        req_d[0] = 1'b0;
        exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
        tick();
        check("rmid_no_late_ack", ack_v, 0);
        check("rmid_p0_stays", p0_rdata, 0);

        // Read data holds across a write on the same port
        do_txn(1, 1'b0, 8'h02, 16'h0000);
        check("hold_read_val", p1_rdata, 16'h2222);
        do_txn(1, 1'b1, 8'h02, 16'h3333);
        check("hold_after_write", p1_rdata, 16'h2222);

        // Single port back-to-back: GRANT, DONE, IDLE, GRANT
        req_d[0] = 1'b1; we_d[0] = 1'b0; addr_d[0] = 8'h12;
        tick();
        check("b2b_grant1", busy, 1);
        tick();
        check("b2b_ack1", ack_v, 2'b01);
        tick();
        check("b2b_idle", busy, 0);
        check("b2b_idle_ack", ack_v, 0);
        tick();
        check("b2b_grant2", busy, 1);
        check("b2b_grant2_port", grant, 0);
        tick();
        check("b2b_ack2", ack_v, 2'b01);
        req_d[0] = 1'b0;
        exp_rd[0] = model_mem[8'h12];
        tick();
        check("b2b_rdata", p0_rdata, 16'hBEEF);

        // Randomized traffic against the memory/arbitration reference model
        for (int i = 0; i < 600; i++) begin
            check("rnd_p0_rdata", p0_rdata, exp_rd[0]);
            check("rnd_p1_rdata", p1_rdata, exp_rd[1]);
            check("rnd_ack_excl", p0_ack & p1_ack, 0);
            if (exp_regrant) begin
                check("rnd_regrant_busy", busy, 1);
                check("rnd_regrant_port", grant, exp_port);
            end
            exp_regrant = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (ack_v[p]) begin
                    check("rnd_ack_had_req", req_d[p], 1);
                    if (we_d[p]) model_mem[addr_d[p]] = wdata_d[p];
                    else         exp_rd[p] = model_mem[addr_d[p]];
                    req_d[p]    = 1'b0;
                    wait_cnt[p] = 0;
                end else if (req_d[p]) begin
                    wait_cnt[p]++;
                    check("rnd_wait_bound", wait_cnt[p] > 60, 0);
                    if (wait_cnt[p] > 60) wait_cnt[p] = 0;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (!req_d[p] && $urandom_range(0, 2) != 0) begin
                    req_d[p]   = 1'b1;
                    we_d[p]    = 1'($urandom_range(0, 1));
                    addr_d[p]  = 8'($urandom_range(0, 7));
                    wdata_d[p] = 16'($urandom);
                end
            end
            halt = ($urandom_range(0, 7) == 0);
            if ((p0_ack || p1_ack) && !halt) begin
                other = p1_ack ? 0 : 1;
                if (req_d[other]) begin
                    exp_regrant = 1'b1;
                    exp_port    = other;
                end
            end
            tick();
        end

        req_d = 2'b00;
        halt  = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port synchronous data RAM between the CPU load/store path (port 0) and the VGA/auxiliary master (port 1). It serialises requests with round-robin priority, drives the RAM address/data/write-enable from registers, and returns a one-cycle acknowledge with read data to the winning requester. It sits between the datapath's memory access stage and the on-chip RAM instance.

## Interface
- ADDR_WIDTH, 8, RAM word-address width.
- DATA_WIDTH, 16, RAM word width.
- clock  in  1  system clock; all state changes on posedge.
- resetn  in  1  reset, synchronous, active-low.
- halt  in  1  when high, no new grant is issued; an in-flight access still completes.
- p0_req, p1_req  in  1 each  request; held high until the matching ack.
- p0_we, p1_we  in  1 each  1 = write, 0 = read; stable while req is high.
- p0_addr, p1_addr  in  ADDR_WIDTH each  word address; stable while req is high.
- p0_wdata, p1_wdata  in  DATA_WIDTH each  write data; stable while req is high.
- p0_ack, p1_ack  out  1 each  one-cycle completion pulse.
- p0_rdata, p1_rdata  out  DATA_WIDTH each  read result; updated only on a read ack; holds otherwise.
- ram_addr  out  ADDR_WIDTH  registered RAM address.
- ram_wdata  out  DATA_WIDTH  registered RAM write data.
- ram_we  out  1  registered RAM write enable.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after the address is presented.
- busy  out  1  high in GRANT and DONE.
- grant  out  1  port owning the current access (0/1); meaningful only while busy.

## Operation
- States: IDLE, GRANT, DONE. Reset enters IDLE; last_winner resets to 1 so port 0 wins the first tie.
- IDLE: if halt low and any req high, pick winner and go to GRANT; else stay.
- Winner selection: only one req high -> that port; both high -> port != last_winner. last_winner updates on every entry to GRANT.
- On entry to GRANT: ram_addr, ram_wdata, ram_we <= winner's addr, wdata, we; grant <= winner. ram_we is high only during GRANT and only for writes.
- GRANT -> DONE unconditionally (one RAM cycle per access).
- DONE: ack of granted port high for exactly this cycle; for a read, that port's rdata <= ram_rdata at the end of DONE (visible next cycle; requesters sample rdata the cycle after ack). ram_we low.
- DONE exit: if halt low and the non-granted port's req is high -> GRANT for that port; else IDLE. The just-acked port is ineligible in DONE (its req is still high that cycle), so a continuously requesting port is re-served via IDLE.
- A requester dropping req before ack is a protocol violation; the access still completes and ack still pulses.
- Address and data are plain ADDR_WIDTH/DATA_WIDTH pass-through; no arithmetic, no wrap logic.

## Timing
- Reset values: all acks 0, ram_we 0, ram_addr 0, ram_wdata 0, p0/p1_rdata 0, busy 0, grant 0, state IDLE.
- resetn low mid-access: next edge forces IDLE and reset values; the aborted access is not acked; a write already issued in GRANT has hit the RAM.
- Uncontended latency: req seen high at edge N (state IDLE) -> GRANT in cycle N+1 -> ack in cycle N+2 -> rdata valid cycle N+3.
- Contended throughput: alternating ports sustain one access per 2 cycles (GRANT, DONE, GRANT, ...).
- Single port re-requesting back-to-back: one access per 3 cycles (GRANT, DONE, IDLE).
- halt rising in GRANT: DONE still acks; then IDLE until halt falls.
- p0_ack and p1_ack are never high in the same cycle.

## Test plan
- Reset: hold resetn low 2 cycles with both req high -> no ack, ram_we 0, busy 0; release -> port 0 granted first (ram_addr = p0_addr).
- Write then read port 0: write 0xBEEF to addr 0x12, then read 0x12 -> p0_ack at cycle N+2 each time, ram_we high exactly 1 cycle, p0_rdata = 0xBEEF after the read ack.
- Contention: both ports request reads continuously (p0 addr 0x01 = 0x1111, p1 addr 0x02 = 0x2222) -> grants alternate 0,1,0,1; acks every 2 cycles; p0_rdata 0x1111, p1_rdata 0x2222.
- Halt: assert halt during a port 1 GRANT with p0 pending -> p1 acked, no further grant while halt high; p0 granted the cycle after halt falls.
- Reset mid-access: port 0 read enters GRANT, resetn low next cycle -> no p0_ack, outputs return to reset values, p0_rdata stays 0.
- rdata hold: port 1 write after a port 1 read of 0x2222 -> p1_rdata remains 0x2222.
